// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: valid/ready register slice with optional skid buffer.
// Squashes byte enables for $zero writes and counts backpressured cycles.
module mem_wb_pipe #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WSEL_W     = 4,
  parameter int OP_W       = 8,
  parameter bit SKID       = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_waddr,
  input  logic [WSEL_W-1:0]     in_wsel,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [PC_W-1:0]       in_pc,
  input  logic [OP_W-1:0]       in_aluop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_waddr,
  output logic [WSEL_W-1:0]     out_wsel,
  output logic [DATA_W-1:0]     out_wdata,
  output logic [PC_W-1:0]       out_pc,
  output logic [OP_W-1:0]       out_aluop,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [WSEL_W-1:0]     wsel;
    logic [DATA_W-1:0]     wdata;
    logic [PC_W-1:0]       pc;
    logic [OP_W-1:0]       aluop;
  } ent_t;

  ent_t in_ent;
  ent_t main_q;
  ent_t out_ent;
  logic vld;
  logic accept;
  logic fire;

  assign accept = in_valid && in_ready;
  assign fire   = vld && out_ready;

  // Incoming entry, with $zero writes squashed at capture
  always_comb begin
    in_ent.waddr = in_waddr;
    in_ent.wsel  = (in_waddr == '0) ? '0 : in_wsel;
    in_ent.wdata = in_wdata;
    in_ent.pc    = in_pc;
    in_ent.aluop = in_aluop;
  end

  if (SKID) begin : g_skid
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state_q;
    state_t state_d;
    ent_t   skid_q;
    logic   rdy_q;
    logic   ld_main;
    logic   ld_from_skid;
    logic   ld_skid;

    // Next state and register load selects
    always_comb begin
      state_d      = state_q;
      ld_main      = 1'b0;
      ld_from_skid = 1'b0;
      ld_skid      = 1'b0;
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            ld_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && !fire) begin
            state_d = TWO;
            ld_skid = 1'b1;
          end else if (accept && fire) begin
            ld_main = 1'b1;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (fire) begin
            state_d      = ONE;
            ld_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // State, payload and registered ready
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        state_q <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        rdy_q   <= (state_d != TWO);
        if (ld_main) begin
          main_q <= in_ent;
        end else if (ld_from_skid) begin
          main_q <= skid_q;
        end
        if (ld_skid) begin
          skid_q <= in_ent;
        end
      end
    end

    assign vld      = (state_q != EMPTY);
    assign in_ready = rdy_q;
  end else begin : g_reg
    logic v_q;

    // Single register slice
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        v_q    <= 1'b0;
        main_q <= '0;
      end else if (accept) begin
        v_q    <= 1'b1;
        main_q <= in_ent;
      end else if (fire) begin
        v_q    <= 1'b0;
      end
    end

    assign vld      = v_q;
    assign in_ready = !v_q || out_ready;
  end

  assign out_ent   = vld ? main_q : '0;
  assign out_valid = vld;
  assign out_waddr = out_ent.waddr;
  assign out_wsel  = out_ent.wsel;
  assign out_wdata = out_ent.wdata;
  assign out_pc    = out_ent.pc;
  assign out_aluop = out_ent.aluop;

  // Saturating backpressure counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (vld && !out_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: both SKID modes driven in lockstep
// against a queue-based model of the stage.
module tb_mem_wb_pipe;

  typedef struct packed {
    logic [4:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] p;
    logic [7:0]  o;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic iv = 1'b0;
  logic ordy = 1'b0;
  ent_t ce = '0;

  logic        ir [2];
  logic        ov [2];
  logic [4:0]  oa [2];
  logic [3:0]  os [2];
  logic [31:0] od [2];
  logic [31:0] op [2];
  logic [7:0]  oo [2];
  logic [15:0] sc0;
  logic [3:0]  sc1;

  ent_t mq [2][2];
  int   mn [2];
  int   ms [2];
  int   mx [2];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_wb_pipe #(.SKID(1'b0)) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv), .in_ready(ir[0]),
    .in_waddr(ce.a), .in_wsel(ce.s), .in_wdata(ce.d),
    .in_pc(ce.p), .in_aluop(ce.o),
    .out_valid(ov[0]), .out_ready(ordy),
    .out_waddr(oa[0]), .out_wsel(os[0]), .out_wdata(od[0]),
    .out_pc(op[0]), .out_aluop(oo[0]),
    .stall_cnt(sc0)
  );

  mem_wb_pipe #(.SKID(1'b1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv), .in_ready(ir[1]),
    .in_waddr(ce.a), .in_wsel(ce.s), .in_wdata(ce.d),
    .in_pc(ce.p), .in_aluop(ce.o),
    .out_valid(ov[1]), .out_ready(ordy),
    .out_waddr(oa[1]), .out_wsel(os[1]), .out_wdata(od[1]),
    .out_pc(op[1]), .out_aluop(oo[1]),
    .stall_cnt(sc1)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_rdy(input int k);
    if (k == 1) return mn[k] < 2;
    return (mn[k] == 0) || ordy;
  endfunction

  function automatic ent_t mk(input logic [4:0] a, input logic [3:0] s,
                              input logic [31:0] d);
    ent_t e;
    e.a = a;
    e.s = s;
    e.d = d;
    e.p = $urandom;
    e.o = 8'($urandom);
    return e;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mn[k] = 0;
        ms[k] = 0;
      end else begin
        bit acc;
        bit fir;
        ent_t e;
        acc = iv && m_rdy(k);
        fir = (mn[k] > 0) && ordy;
        if (mn[k] > 0 && !ordy && ms[k] < mx[k]) ms[k]++;
        if (flush) begin
          mn[k] = 0;
        end else begin
          if (fir) begin
            mq[k][0] = mq[k][1];
            mn[k]--;
          end
          if (acc) begin
            e = ce;
            if (e.a == 5'd0) e.s = 4'd0;
            mq[k][mn[k]] = e;
            mn[k]++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    ent_t e;
    logic [15:0] sc;
    for (int k = 0; k < 2; k++) begin
      e = (mn[k] > 0) ? mq[k][0] : '0;
      sc = (k == 0) ? sc0 : {12'd0, sc1};
      chk($sformatf("s%0d_valid", k), 64'(ov[k]), 64'(mn[k] > 0));
      chk($sformatf("s%0d_ready", k), 64'(ir[k]), 64'(m_rdy(k)));
      chk($sformatf("s%0d_waddr", k), 64'(oa[k]), 64'(e.a));
      chk($sformatf("s%0d_wsel", k), 64'(os[k]), 64'(e.s));
      chk($sformatf("s%0d_wdata", k), 64'(od[k]), 64'(e.d));
      chk($sformatf("s%0d_pc", k), 64'(op[k]), 64'(e.p));
      chk($sformatf("s%0d_aluop", k), 64'(oo[k]), 64'(e.o));
      chk($sformatf("s%0d_stall", k), 64'(sc), 64'(ms[k]));
    end
  endtask

  task automatic cyc(input bit r, input bit f, input bit v,
                     input bit ord, input ent_t e);
    rst = r;
    flush = f;
    iv = v;
    ordy = ord;
    ce = e;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    ent_t z;
    z = '0;
    mx[0] = 65535;
    mx[1] = 15;
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0;
      ms[k] = 0;
    end

    repeat (3) cyc(1, 0, 0, 0, z);

    for (int i = 0; i < 8; i++)
      cyc(0, 0, 1, 1, mk(5'(i + 1), 4'hF, 32'h1000 + i));

    cyc(0, 0, 1, 1, mk(5'd0, 4'hF, 32'hDEADBEEF));
    repeat (2) cyc(0, 0, 0, 1, z);

    cyc(0, 0, 1, 0, mk(5'd3, 4'h3, 32'hA));
    cyc(0, 0, 1, 0, mk(5'd4, 4'hC, 32'hB));
    repeat (3) cyc(0, 0, 1, 0, mk(5'd5, 4'h1, 32'hC));
    repeat (4) cyc(0, 0, 0, 1, z);

    cyc(0, 0, 1, 0, mk(5'd6, 4'hF, 32'h11));
    cyc(0, 0, 1, 0, mk(5'd7, 4'hF, 32'h22));
    cyc(0, 1, 1, 0, mk(5'd8, 4'hF, 32'h33));
    repeat (2) cyc(0, 0, 0, 1, z);

    cyc(0, 0, 1, 0, mk(5'd9, 4'h5, 32'h44));
    repeat (22) cyc(0, 0, 0, 0, z);
    repeat (3) cyc(0, 0, 0, 1, z);

    cyc(0, 0, 1, 0, mk(5'd10, 4'hF, 32'h55));
    cyc(0, 0, 1, 0, mk(5'd11, 4'hF, 32'h66));
    cyc(0, 0, 1, 1, mk(5'd11, 4'hF, 32'h66));
    repeat (3) cyc(0, 0, 0, 1, z);

    for (int i = 0; i < 600; i++) begin
      bit r;
      bit f;
      bit v;
      bit o;
      logic [4:0] a;
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 99) < ((i % 100 < 50) ? 80 : 30));
      a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cyc(r, f, v, o, mk(a, 4'($urandom), $urandom));
    end
    repeat (4) cyc(0, 0, 0, 1, z);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
